// File: rtl/sd_req_arbiter_if.sv
// Client-side and SD-wrapper-side bundles of the sector request arbiter.
// Clients are masters of sd_req_client_if; the arbiter is master of sd_req_sd_if.
interface sd_req_client_if #(
  parameter int CLIENTS = 4
);
  logic [CLIENTS-1:0]    req_rd;
  logic [CLIENTS-1:0]    req_wr;
  logic [32*CLIENTS-1:0] req_sector;
  logic [CLIENTS-1:0]    ack;
  logic [CLIENTS-1:0]    err;
  logic [CLIENTS-1:0]    busy;
  logic [CLIENTS-1:0]    c_outen;
  logic [8:0]            c_outaddr;
  logic [7:0]            c_outbyte;
  logic [8*CLIENTS-1:0]  c_inbyte;

  modport master (
    output req_rd, req_wr, req_sector, c_inbyte,
    input  ack, err, busy, c_outen, c_outaddr, c_outbyte
  );

  modport slave (
    input  req_rd, req_wr, req_sector, c_inbyte,
    output ack, err, busy, c_outen, c_outaddr, c_outbyte
  );
endinterface

interface sd_req_sd_if;
  logic [1:0]  sd_rstart;
  logic [1:0]  sd_wstart;
  logic [31:0] sd_sector;
  logic        sd_rbusy;
  logic        sd_rdone;
  logic        sd_outen;
  logic [8:0]  sd_outaddr;
  logic [7:0]  sd_outbyte;
  logic [7:0]  sd_inbyte;

  modport master (
    output sd_rstart, sd_wstart, sd_sector, sd_inbyte,
    input  sd_rbusy, sd_rdone, sd_outen, sd_outaddr, sd_outbyte
  );

  modport slave (
    input  sd_rstart, sd_wstart, sd_sector, sd_inbyte,
    output sd_rbusy, sd_rdone, sd_outen, sd_outaddr, sd_outbyte
  );
endinterface

// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter sharing one single-outstanding SD sector interface
// between CLIENTS requesters, with byte-stream routing and optional watchdog.
module sd_req_arbiter #(
  parameter int          CLIENTS   = 4,
  parameter logic [7:0]  DRIVE_MAP = 8'b0000_0010,
  parameter logic [31:0] TIMEOUT   = 32'd0
) (
  input  logic            clk,
  input  logic            rstn,
  sd_req_client_if.slave  cl,
  sd_req_sd_if.master     sd
);

  localparam int IW = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      g_q, g_d;
  logic [31:0]        sector_q, sector_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [1:0]         rstart_q, rstart_d;
  logic [1:0]         wstart_q, wstart_d;
  logic [CLIENTS-1:0] ack_q, ack_d;
  logic [CLIENTS-1:0] err_q, err_d;
  logic [CLIENTS-1:0] busy_q, busy_d;

  logic [CLIENTS-1:0] pend_s;
  logic               any_pend_s;
  logic [IW-1:0]      grant_s;
  logic [3:0]         rr_sum_s;
  logic [CLIENTS-1:0] g_onehot_s;
  logic               done_s;
  logic               tmo_s;
  logic               unused_rbusy_s;

  assign done_s         = sd.sd_rdone;
  assign tmo_s          = (TIMEOUT != 32'd0) && (cnt_q == (TIMEOUT - 32'd1));
  assign g_onehot_s     = CLIENTS'(1'b1) << g_q;
  assign unused_rbusy_s = sd.sd_rbusy;

  // Round-robin pick: the pending client with the smallest offset from the pointer wins.
  always_comb begin
    pend_s     = cl.req_rd | cl.req_wr;
    any_pend_s = |pend_s;
    grant_s    = ptr_q;
    rr_sum_s   = 4'd0;
    for (int k = CLIENTS - 1; k >= 0; k--) begin
      rr_sum_s = 4'(ptr_q) + 4'(k);
      if (rr_sum_s >= 4'(CLIENTS)) begin
        rr_sum_s = rr_sum_s - 4'(CLIENTS);
      end else begin
        rr_sum_s = rr_sum_s;
      end
      if (pend_s[rr_sum_s[IW-1:0]]) begin
        grant_s = rr_sum_s[IW-1:0];
      end else begin
        grant_s = grant_s;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      ptr_q    <= {IW{1'b0}};
      g_q      <= {IW{1'b0}};
      sector_q <= 32'd0;
      cnt_q    <= 32'd0;
      rstart_q <= 2'b00;
      wstart_q <= 2'b00;
      ack_q    <= {CLIENTS{1'b0}};
      err_q    <= {CLIENTS{1'b0}};
      busy_q   <= {CLIENTS{1'b0}};
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      g_q      <= g_d;
      sector_q <= sector_d;
      cnt_q    <= cnt_d;
      rstart_q <= rstart_d;
      wstart_q <= wstart_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_pend_s) state_d = BUSY;
        else            state_d = IDLE;
      end
      BUSY: begin
        if (done_s || tmo_s) state_d = RELEASE;
        else                 state_d = BUSY;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; grant context is frozen while BUSY.
  always_comb begin
    ptr_d    = ptr_q;
    g_d      = g_q;
    sector_d = sector_q;
    cnt_d    = cnt_q;
    rstart_d = rstart_q;
    wstart_d = wstart_q;
    ack_d    = {CLIENTS{1'b0}};
    err_d    = {CLIENTS{1'b0}};
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (any_pend_s) begin
          g_d      = grant_s;
          sector_d = cl.req_sector[{grant_s, 5'd0} +: 32];
          busy_d   = CLIENTS'(1'b1) << grant_s;
          cnt_d    = 32'd0;
          if (cl.req_rd[grant_s]) begin
            rstart_d = DRIVE_MAP[3'(grant_s)] ? 2'b10 : 2'b01;
            wstart_d = 2'b00;
          end else begin
            rstart_d = 2'b00;
            wstart_d = DRIVE_MAP[3'(grant_s)] ? 2'b10 : 2'b01;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      BUSY: begin
        if (done_s || tmo_s) begin
          rstart_d = 2'b00;
          wstart_d = 2'b00;
          busy_d   = {CLIENTS{1'b0}};
          ack_d    = g_onehot_s;
          // A done pulse coinciding with expiry still counts as success.
          err_d    = done_s ? {CLIENTS{1'b0}} : g_onehot_s;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RELEASE: begin
        if (g_q == IW'(CLIENTS - 1)) ptr_d = {IW{1'b0}};
        else                         ptr_d = g_q + IW'(1);
      end
      default: begin
        rstart_d = 2'b00;
        wstart_d = 2'b00;
        busy_d   = {CLIENTS{1'b0}};
      end
    endcase
  end

  // Byte-stream routing to and from the granted client, only while BUSY.
  always_comb begin
    cl.c_outen   = {CLIENTS{1'b0}};
    sd.sd_inbyte = 8'd0;
    if (state_q == BUSY) begin
      cl.c_outen   = sd.sd_outen ? g_onehot_s : {CLIENTS{1'b0}};
      sd.sd_inbyte = cl.c_inbyte[{g_q, 3'd0} +: 8];
    end else begin
      cl.c_outen   = {CLIENTS{1'b0}};
      sd.sd_inbyte = 8'd0;
    end
  end

  assign cl.ack       = ack_q;
  assign cl.err       = err_q;
  assign cl.busy      = busy_q;
  assign cl.c_outaddr = sd.sd_outaddr;
  assign cl.c_outbyte = sd.sd_outbyte;
  assign sd.sd_rstart = rstart_q;
  assign sd.sd_wstart = wstart_q;
  assign sd.sd_sector = sector_q;

endmodule
